// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - registered raster timing generator (x/y counters, syncs, DE, start pulses)
// Define VIDEO_TIMING_FRAME_COUNTER_EN to add the 16-bit o_frame_cnt output.
module video_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_line_start,
    output logic        o_frame_start
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam logic [15:0] H_TOTAL   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] V_TOTAL   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] H_ACT     = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT     = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START  = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END    = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START  = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FP + V_SYNC);

    // primed is clear until position (0,0) has been presented once after reset,
    // so the first running edge shows the origin instead of advancing past it.
    logic        primed;
    logic [15:0] x_nxt;
    logic [15:0] y_nxt;
    logic        frame_wrap;

    always_comb begin
        x_nxt      = o_x;
        y_nxt      = o_y;
        frame_wrap = 1'b0;
        if (primed) begin
            if (o_x == H_TOTAL - 16'd1) begin
                x_nxt = 16'd0;
                if (o_y == V_TOTAL - 16'd1) begin
                    y_nxt      = 16'd0;
                    frame_wrap = 1'b1;
                end else begin
                    y_nxt = o_y + 16'd1;
                end
            end else begin
                x_nxt = o_x + 16'd1;
            end
        end
    end

    // Every decode uses the next position so it lands in the same register stage as o_x/o_y.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            primed        <= 1'b0;
            o_x           <= 16'd0;
            o_y           <= 16'd0;
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_de          <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (i_en) begin
            primed        <= 1'b1;
            o_x           <= x_nxt;
            o_y           <= y_nxt;
            o_hsync       <= (x_nxt >= HS_START && x_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= (y_nxt >= VS_START && y_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
            o_de          <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
            o_line_start  <= (x_nxt == 16'd0);
            o_frame_start <= (x_nxt == 16'd0) && (y_nxt == 16'd0);
        end else begin
            o_de          <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end
    end

`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frame_cnt <= 16'd0;
        end else if (i_en && frame_wrap) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end
`endif

endmodule
